// File: rtl/ttt_nk_engine.sv
// m,n,k game engine: N x N board, K in a row wins, validated ready/valid moves and a
// fixed 4-cycle win check around the last move. Draw detection is enabled by TTT_DRAW_DETECT_EN.
module ttt_nk_engine #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          new_game,
    input  logic          move_valid,
    input  logic [CW-1:0] move_row,
    input  logic [CW-1:0] move_col,
    output logic          move_ready,
    output logic          illegal,
    output logic          turn,
    output logic [1:0]    winner,
    output logic          draw,
    output logic          game_over,
    input  logic [CW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [1:0]    rd_mark
);
    localparam int CELLS = N * N;
    localparam int IW    = $clog2(CELLS);
    localparam int MCW   = $clog2(CELLS + 1);
`ifdef TTT_DRAW_DETECT_EN
    localparam bit DRAW_EN = 1'b1;
`else
    localparam bit DRAW_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_OVER
    } state_t;

    state_t         state;
    logic [1:0]     board [CELLS];
    logic [1:0]     dir;
    logic           hit;
    logic           starter;
    logic           draw_q;
    logic [CW-1:0]  last_row;
    logic [CW-1:0]  last_col;
    logic [MCW-1:0] move_cnt;

    logic [1:0]     mover_mark;
    logic           move_in_range;
    logic           target_empty;
    logic           board_full;
    logic           next_starter;
    logic           run_hit;
    int             dr;
    int             dc;
    int             run_len;

    function automatic logic in_range(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return (int'(r) < N) && (int'(c) < N);
    endfunction

    function automatic logic [IW-1:0] idx(input int r, input int c);
        return IW'(r * N + c);
    endfunction

    // Same-mark cells beyond the last move in one direction, stopping at a gap or the edge.
    function automatic int run_side(input int sr, input int sc);
        int   n;
        int   r;
        int   c;
        logic go_on;
        n     = 0;
        go_on = 1'b1;
        for (int i = 1; i < K; i++) begin
            r = int'(last_row) + i * sr;
            c = int'(last_col) + i * sc;
            if (go_on && r >= 0 && r < N && c >= 0 && c < N && board[idx(r, c)] == mover_mark)
                n++;
            else
                go_on = 1'b0;
        end
        return n;
    endfunction

    assign mover_mark    = turn ? 2'b10 : 2'b01;
    assign move_in_range = in_range(move_row, move_col);
    assign target_empty  = board[idx(int'(move_row), int'(move_col))] == 2'b00;
    assign board_full    = move_cnt == MCW'(CELLS);
    assign next_starter  = (winner != 2'b00) ? winner[1] : ~starter;
    assign draw          = DRAW_EN & draw_q;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        dr = 0;
        dc = 1;
        case (dir)
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            2'd3:    begin dr = 1; dc = -1; end
            default: ;
        endcase
        run_len = 1 + run_side(dr, dc) + run_side(-dr, -dc);
    end

    assign run_hit = run_len >= K;

    // NOTE: all state uses non-blocking assignments so every update lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            dir        <= 2'd0;
            hit        <= 1'b0;
            starter    <= 1'b0;
            turn       <= 1'b0;
            winner     <= 2'b00;
            draw_q     <= 1'b0;
            game_over  <= 1'b0;
            move_ready <= 1'b1;
            illegal    <= 1'b0;
            rd_mark    <= 2'b00;
            last_row   <= '0;
            last_col   <= '0;
            move_cnt   <= '0;
            // NOTE: the board is reset cell by cell because an empty board is part of the reset state.
            for (int i = 0; i < CELLS; i++) board[i] <= 2'b00;
        end else begin
            illegal <= 1'b0;
            rd_mark <= in_range(rd_row, rd_col) ? board[idx(int'(rd_row), int'(rd_col))] : 2'b00;

            if (new_game) begin
                state      <= S_IDLE;
                dir        <= 2'd0;
                hit        <= 1'b0;
                starter    <= next_starter;
                turn       <= next_starter;
                winner     <= 2'b00;
                draw_q     <= 1'b0;
                game_over  <= 1'b0;
                move_ready <= 1'b1;
                move_cnt   <= '0;
                for (int i = 0; i < CELLS; i++) board[i] <= 2'b00;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (move_valid) begin
                            if (move_in_range && target_empty) begin
                                board[idx(int'(move_row), int'(move_col))] <= mover_mark;
                                last_row   <= move_row;
                                last_col   <= move_col;
                                move_cnt   <= move_cnt + 1'b1;
                                dir        <= 2'd0;
                                hit        <= 1'b0;
                                move_ready <= 1'b0;
                                state      <= S_CHECK;
                            end else begin
                                illegal <= 1'b1;
                            end
                        end
                    end

                    S_CHECK: begin
                        dir <= dir + 2'd1;
                        if (run_hit) hit <= 1'b1;
                        if (dir == 2'd3) begin
                            if (hit || run_hit) begin
                                winner    <= mover_mark;
                                game_over <= 1'b1;
                                state     <= S_OVER;
                            end else if (DRAW_EN && board_full) begin
                                draw_q    <= 1'b1;
                                game_over <= 1'b1;
                                state     <= S_OVER;
                            end else begin
                                turn       <= ~turn;
                                move_ready <= 1'b1;
                                state      <= S_IDLE;
                            end
                        end
                    end

                    S_OVER: ;

                    default: begin
                        state      <= S_IDLE;
                        move_ready <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
